mem_stage_lsu: RTL and testbench

- Load/store unit occupying the memory stage of the five-stage RISC-V pipeline.
- Consumes the execute-stage output bundle and drives a variable-latency data-memory port using a req/gnt/rvalid handshake.
- Formats loads (sign/zero extension) and stores (byte enables, lane replication).
- Raises a stall back to fetch/decode/execute while a memory access is outstanding.
- Produces the registered bundle consumed by writeback.

---
 rtl/mem_stage_lsu.sv | 254 +++++++++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: formats loads/stores, drives a req/gnt/rvalid
// data port, stalls upstream while an access is outstanding, registers the writeback bundle.
module mem_stage_lsu #(
    parameter int unsigned RESP_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        in_mem_read,
    input  logic        in_mem_write,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_alu_result,
    input  logic [31:0] in_wdata,
    input  logic [4:0]  in_rd,
    input  logic        in_reg_write,
    input  logic        in_is_final,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        out_valid,
    output logic [4:0]  out_rd,
    output logic        out_reg_write,
    output logic [31:0] out_data,
    output logic        out_is_final,
    output logic        fault
);

    localparam int unsigned CNT_W = (RESP_TIMEOUT < 2) ? 1 : $clog2(RESP_TIMEOUT);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(RESP_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] tmo_cnt_r;
    logic [1:0]       off_s;
    logic             is_mem_s;
    logic             illegal_s;
    logic             legal_s;
    logic             tmo_hit_s;
    logic             req_s;
    logic             stall_s;
    logic             abort_s;

    function automatic logic access_illegal(input logic rd, input logic wr,
                                            input logic [2:0] f3, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        if (rd && wr) begin
            bad = 1'b1;
        end else if (rd) begin
            case (f3)
                3'b000, 3'b100: bad = 1'b0;
                3'b001, 3'b101: bad = off[0];
                3'b010:         bad = (off != 2'b00);
                default:        bad = 1'b1;
            endcase
        end else if (wr) begin
            case (f3)
                3'b000:  bad = 1'b0;
                3'b001:  bad = off[0];
                3'b010:  bad = (off != 2'b00);
                default: bad = 1'b1;
            endcase
        end else begin
            bad = 1'b0;
        end
        return bad;
    endfunction

    function automatic logic [3:0] store_be(input logic is_store, input logic [2:0] f3,
                                            input logic [1:0] off);
        logic [3:0] be;
        if (!is_store) begin
            be = 4'b1111;
        end else begin
            case (f3[1:0])
                2'b00:   be = 4'b0001 << off;
                2'b01:   be = 4'b0011 << off;
                default: be = 4'b1111;
            endcase
        end
        return be;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] data);
        logic [31:0] w;
        case (f3[1:0])
            2'b00:   w = {4{data[7:0]}};
            2'b01:   w = {2{data[15:0]}};
            default: w = data;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] load_format(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] rdata);
        logic [31:0] sh;
        logic [31:0] r;
        sh = rdata >> {off, 3'b000};
        case (f3)
            3'b000:  r = {{24{sh[7]}}, sh[7:0]};
            3'b100:  r = {24'h00_0000, sh[7:0]};
            3'b001:  r = {{16{sh[15]}}, sh[15:0]};
            3'b101:  r = {16'h0000, sh[15:0]};
            default: r = rdata;
        endcase
        return r;
    endfunction

    // Access classification, request/stall generation and timeout abort detection.
    always_comb begin
        off_s     = in_alu_result[1:0];
        is_mem_s  = in_valid && (in_mem_read || in_mem_write);
        illegal_s = is_mem_s && access_illegal(in_mem_read, in_mem_write, in_funct3, off_s);
        legal_s   = is_mem_s && !illegal_s;
        tmo_hit_s = (tmo_cnt_r == TMO_LAST);
        req_s     = 1'b0;
        stall_s   = 1'b0;
        abort_s   = 1'b0;
        case (state_r)
            IDLE: begin
                req_s   = legal_s;
                stall_s = legal_s && (in_mem_read || !dmem_gnt);
            end
            REQ: begin
                req_s = 1'b1;
                if (dmem_gnt) begin
                    stall_s = in_mem_read;
                end else begin
                    stall_s = !tmo_hit_s;
                    abort_s = tmo_hit_s;
                end
            end
            RESP: begin
                if (dmem_rvalid) begin
                    stall_s = 1'b0;
                end else begin
                    stall_s = !tmo_hit_s;
                    abort_s = tmo_hit_s;
                end
            end
            default: begin
                req_s   = 1'b0;
                stall_s = 1'b0;
                abort_s = 1'b0;
            end
        endcase
    end

    // Reset overrides the combinational handshake so nothing leaks while it is held.
    assign stall      = stall_s && !reset;
    assign dmem_req   = req_s && !reset;
    assign dmem_we    = in_mem_write;
    assign dmem_addr  = {in_alu_result[31:2], 2'b00};
    assign dmem_be    = store_be(in_mem_write, in_funct3, off_s);
    assign dmem_wdata = store_lanes(in_funct3, in_wdata);

    // Access FSM, timeout counter and the registered writeback bundle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= IDLE;
            tmo_cnt_r     <= '0;
            out_valid     <= 1'b0;
            out_rd        <= 5'd0;
            out_reg_write <= 1'b0;
            out_data      <= 32'h0000_0000;
            out_is_final  <= 1'b0;
            fault         <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    tmo_cnt_r <= '0;
                    if (stall_s) begin
                        state_r <= (in_mem_read && dmem_gnt) ? RESP : REQ;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                REQ: begin
                    if (abort_s) begin
                        state_r   <= IDLE;
                        tmo_cnt_r <= '0;
                    end else if (dmem_gnt) begin
                        state_r   <= in_mem_read ? RESP : IDLE;
                        tmo_cnt_r <= '0;
                    end else begin
                        state_r   <= REQ;
                        tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (dmem_rvalid || abort_s) begin
                        state_r   <= IDLE;
                        tmo_cnt_r <= '0;
                    end else begin
                        state_r   <= RESP;
                        tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    tmo_cnt_r <= '0;
                end
            endcase

            // A stalled cycle emits a bubble; every completion path carries rd and the final marker.
            if (stall_s) begin
                out_valid     <= 1'b0;
                out_reg_write <= 1'b0;
                fault         <= 1'b0;
            end else begin
                out_rd       <= in_rd;
                out_is_final <= in_is_final;
                if (abort_s) begin
                    out_valid     <= 1'b1;
                    out_reg_write <= 1'b0;
                    out_data      <= in_alu_result;
                    fault         <= 1'b1;
                end else if (state_r == RESP) begin
                    out_valid     <= 1'b1;
                    out_reg_write <= in_reg_write;
                    out_data      <= load_format(in_funct3, off_s, dmem_rdata);
                    fault         <= 1'b0;
                end else if (!in_valid) begin
                    out_valid     <= 1'b0;
                    out_reg_write <= 1'b0;
                    out_data      <= in_alu_result;
                    fault         <= 1'b0;
                end else if (illegal_s || in_mem_write) begin
                    out_valid     <= 1'b1;
                    out_reg_write <= 1'b0;
                    out_data      <= in_alu_result;
                    fault         <= illegal_s;
                end else begin
                    out_valid     <= 1'b1;
                    out_reg_write <= in_reg_write;
                    out_data      <= in_alu_result;
                    fault         <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: single-cycle vector table plus multi-cycle access sequences.
module tb_mem_stage_lsu;

    logic        clk, reset;
    logic        in_valid, in_mem_read, in_mem_write;
    logic [2:0]  in_funct3;
    logic [31:0] in_alu_result, in_wdata;
    logic [4:0]  in_rd;
    logic        in_reg_write, in_is_final;
    logic        stall, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        out_valid;
    logic [4:0]  out_rd;
    logic        out_reg_write;
    logic [31:0] out_data;
    logic        out_is_final, fault;

    int n_cmp = 0;
    int n_fail = 0;
    logic mon_en = 1'b0;
    logic [31:0] mon_q[$];

    mem_stage_lsu #(.RESP_TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
        .in_funct3(in_funct3), .in_alu_result(in_alu_result), .in_wdata(in_wdata),
        .in_rd(in_rd), .in_reg_write(in_reg_write), .in_is_final(in_is_final),
        .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .out_valid(out_valid), .out_rd(out_rd), .out_reg_write(out_reg_write),
        .out_data(out_data), .out_is_final(out_is_final), .fault(fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (mon_en && out_valid) mon_q.push_back(out_data);
    end

    typedef struct {
        logic        valid, mr, mw;
        logic [2:0]  f3;
        logic [31:0] alu, wdata;
        logic        rw, fin, gnt;
        logic        e_req, e_we;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_stall, e_valid, e_rw, chk_data;
        logic [31:0] e_data;
        logic        e_fault;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0;
        in_funct3 = 3'b000; in_alu_result = 32'h0; in_wdata = 32'h0;
        in_rd = 5'd0; in_reg_write = 1'b0; in_is_final = 1'b0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    endtask

    task automatic run_access(input string tag, input logic store, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int gnt_delay, input int rv_delay,
                              input int e_stall, input int e_req, input logic [3:0] e_be,
                              input logic [31:0] e_wdata, input logic [31:0] e_data,
                              input logic e_fault);
        int stall_cnt = 0;
        int req_cnt = 0;
        logic done = 1'b0;
        in_valid = 1'b1; in_mem_read = !store; in_mem_write = store;
        in_funct3 = f3; in_alu_result = addr; in_wdata = wdata;
        in_rd = 5'd9; in_reg_write = 1'b1; in_is_final = 1'b1;
        for (int c = 0; c < 40 && !done; c++) begin
            dmem_gnt    = (c == gnt_delay);
            dmem_rvalid = !store && (c == gnt_delay + rv_delay);
            dmem_rdata  = dmem_rvalid ? rdata : 32'hDEAD_0000;
            @(negedge clk);
            if (dmem_req) begin
                req_cnt++;
                check({tag, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
                check({tag, "_be"}, {28'h0, dmem_be}, {28'h0, e_be});
                check({tag, "_we"}, {31'h0, dmem_we}, {31'h0, store});
                if (store) check({tag, "_wdata"}, dmem_wdata, e_wdata);
            end
            if (stall) stall_cnt++;
            else done = 1'b1;
            @(posedge clk); #1;
        end
        idle_inputs();
        check({tag, "_done"}, {31'h0, done}, 32'h1);
        check({tag, "_stall_cycles"}, stall_cnt, e_stall);
        check({tag, "_req_cycles"}, req_cnt, e_req);
        check({tag, "_fault"}, {31'h0, fault}, {31'h0, e_fault});
        check({tag, "_reg_write"}, {31'h0, out_reg_write}, {31'h0, !store && !e_fault});
        check({tag, "_final"}, {31'h0, out_is_final}, 32'h1);
        if (!e_fault) begin
            check({tag, "_valid"}, {31'h0, out_valid}, 32'h1);
            check({tag, "_rd"}, {27'h0, out_rd}, 32'd9);
            if (!store) check({tag, "_data"}, out_data, e_data);
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        @(posedge clk); #1;
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_out_rw", {31'h0, out_reg_write}, 32'h0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_out_rd", {27'h0, out_rd}, 32'h0);
        check("rst_out_final", {31'h0, out_is_final}, 32'h0);
        check("rst_fault", {31'h0, fault}, 32'h0);
        check("rst_stall", {31'h0, stall}, 32'h0);
        check("rst_req", {31'h0, dmem_req}, 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        //          valid mr    mw    f3      alu            wdata          rw    fin   gnt   req   we    be       e_wdata        stall valid rw    chk   e_data         fault
        vecs[0]  = '{1'b1,1'b0,1'b0,3'b000,32'h1234_5678,32'h0,        1'b1,1'b0,1'b0,1'b0,1'b0,4'b0000,32'h0,        1'b0,1'b1,1'b1,1'b1,32'h1234_5678,1'b0};
        vecs[1]  = '{1'b0,1'b0,1'b0,3'b000,32'h0000_0044,32'h0,        1'b1,1'b0,1'b0,1'b0,1'b0,4'b0000,32'h0,        1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0};
        vecs[2]  = '{1'b1,1'b1,1'b0,3'b010,32'h0000_0006,32'h0,        1'b1,1'b0,1'b1,1'b0,1'b0,4'b0000,32'h0,        1'b0,1'b1,1'b0,1'b0,32'h0,        1'b1};
        vecs[3]  = '{1'b1,1'b1,1'b0,3'b001,32'h0000_0101,32'h0,        1'b1,1'b1,1'b1,1'b0,1'b0,4'b0000,32'h0,        1'b0,1'b1,1'b0,1'b0,32'h0,        1'b1};
        vecs[4]  = '{1'b1,1'b1,1'b1,3'b010,32'h0000_0100,32'h0,        1'b1,1'b0,1'b1,1'b0,1'b0,4'b0000,32'h0,        1'b0,1'b1,1'b0,1'b0,32'h0,        1'b1};
        vecs[5]  = '{1'b1,1'b1,1'b0,3'b011,32'h0000_0000,32'h0,        1'b1,1'b0,1'b1,1'b0,1'b0,4'b0000,32'h0,        1'b0,1'b1,1'b0,1'b0,32'h0,        1'b1};
        vecs[6]  = '{1'b1,1'b0,1'b1,3'b100,32'h0000_0000,32'h0,        1'b0,1'b0,1'b1,1'b0,1'b0,4'b0000,32'h0,        1'b0,1'b1,1'b0,1'b0,32'h0,        1'b1};
        vecs[7]  = '{1'b1,1'b0,1'b1,3'b000,32'h0000_0103,32'h0000_00A5,1'b1,1'b1,1'b1,1'b1,1'b1,4'b1000,32'hA5A5_A5A5,1'b0,1'b1,1'b0,1'b0,32'h0,        1'b0};
        vecs[8]  = '{1'b1,1'b0,1'b1,3'b010,32'h0000_0010,32'hDEAD_BEEF,1'b1,1'b0,1'b1,1'b1,1'b1,4'b1111,32'hDEAD_BEEF,1'b0,1'b1,1'b0,1'b0,32'h0,        1'b0};
        vecs[9]  = '{1'b1,1'b0,1'b1,3'b001,32'h0000_0000,32'h1234_CAFE,1'b0,1'b0,1'b1,1'b1,1'b1,4'b0011,32'hCAFE_CAFE,1'b0,1'b1,1'b0,1'b0,32'h0,        1'b0};
        vecs[10] = '{1'b1,1'b0,1'b0,3'b000,32'hFFFF_FFFF,32'h0,        1'b0,1'b1,1'b0,1'b0,1'b0,4'b0000,32'h0,        1'b0,1'b1,1'b0,1'b1,32'hFFFF_FFFF,1'b0};
        vecs[11] = '{1'b1,1'b0,1'b1,3'b010,32'h0000_0012,32'h0,        1'b1,1'b0,1'b1,1'b0,1'b0,4'b0000,32'h0,        1'b0,1'b1,1'b0,1'b0,32'h0,        1'b1};

        for (int i = 0; i < 12; i++) begin
            in_valid = vecs[i].valid; in_mem_read = vecs[i].mr; in_mem_write = vecs[i].mw;
            in_funct3 = vecs[i].f3; in_alu_result = vecs[i].alu; in_wdata = vecs[i].wdata;
            in_rd = 5'(i + 1); in_reg_write = vecs[i].rw; in_is_final = vecs[i].fin;
            dmem_gnt = vecs[i].gnt;
            @(negedge clk);
            check($sformatf("v%0d_stall", i), {31'h0, stall}, {31'h0, vecs[i].e_stall});
            check($sformatf("v%0d_req", i), {31'h0, dmem_req}, {31'h0, vecs[i].e_req});
            if (vecs[i].e_req) begin
                check($sformatf("v%0d_we", i), {31'h0, dmem_we}, {31'h0, vecs[i].e_we});
                check($sformatf("v%0d_be", i), {28'h0, dmem_be}, {28'h0, vecs[i].e_be});
                check($sformatf("v%0d_wdata", i), dmem_wdata, vecs[i].e_wdata);
                check($sformatf("v%0d_addr", i), dmem_addr, {vecs[i].alu[31:2], 2'b00});
            end
            @(posedge clk); #1;
            check($sformatf("v%0d_out_valid", i), {31'h0, out_valid}, {31'h0, vecs[i].e_valid});
            check($sformatf("v%0d_out_rw", i), {31'h0, out_reg_write}, {31'h0, vecs[i].e_rw});
            check($sformatf("v%0d_fault", i), {31'h0, fault}, {31'h0, vecs[i].e_fault});
            if (vecs[i].chk_data) check($sformatf("v%0d_data", i), out_data, vecs[i].e_data);
            if (vecs[i].e_valid) begin
                check($sformatf("v%0d_rd", i), {27'h0, out_rd}, 32'(i + 1));
                check($sformatf("v%0d_final", i), {31'h0, out_is_final}, {31'h0, vecs[i].fin});
            end
        end
        idle_inputs();
        @(posedge clk); #1;
        check("fault_one_cycle", {31'h0, fault}, 32'h0);

        // Loads: stall = gnt_delay + rv_delay, requests = gnt_delay + 1.
        run_access("lb_103",  1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 0, 3, 3, 1, 4'b1111, 32'h0, 32'hFFFF_FF80, 1'b0);
        run_access("lb_101",  1'b0, 3'b000, 32'h101, 32'h0, 32'h80FF_1234, 0, 1, 1, 1, 4'b1111, 32'h0, 32'h0000_0012, 1'b0);
        run_access("lbu_102", 1'b0, 3'b100, 32'h102, 32'h0, 32'h80FF_1234, 1, 1, 2, 2, 4'b1111, 32'h0, 32'h0000_00FF, 1'b0);
        run_access("lh_102",  1'b0, 3'b001, 32'h102, 32'h0, 32'h80FF_1234, 0, 1, 1, 1, 4'b1111, 32'h0, 32'hFFFF_80FF, 1'b0);
        run_access("lhu_100", 1'b0, 3'b101, 32'h100, 32'h0, 32'h80FF_1234, 2, 2, 4, 3, 4'b1111, 32'h0, 32'h0000_1234, 1'b0);
        run_access("lw_100",  1'b0, 3'b010, 32'h100, 32'h0, 32'h80FF_1234, 0, 1, 1, 1, 4'b1111, 32'h0, 32'h80FF_1234, 1'b0);
        // Stores: stall = gnt_delay, requests = gnt_delay + 1.
        run_access("sh_202",  1'b1, 3'b001, 32'h202, 32'h0000_BEEF, 32'h0, 3, 1, 3, 4, 4'b1100, 32'hBEEF_BEEF, 32'h0, 1'b0);
        run_access("sb_001",  1'b1, 3'b000, 32'h001, 32'h0000_0077, 32'h0, 1, 1, 1, 2, 4'b0010, 32'h7777_7777, 32'h0, 1'b0);
        // Granted load, rvalid never returns: 8 stalled cycles then abort.
        run_access("timeout", 1'b0, 3'b010, 32'h000, 32'h0, 32'h0, 0, 1000, 8, 1, 4'b1111, 32'h0, 32'h0, 1'b1);
        @(posedge clk); #1;
        check("timeout_fault_pulse", {31'h0, fault}, 32'h0);
        run_access("after_tmo", 1'b0, 3'b010, 32'h004, 32'h0, 32'h1357_9BDF, 0, 1, 1, 1, 4'b1111, 32'h0, 32'h1357_9BDF, 1'b0);

        // Reset while waiting in RESP.
        in_valid = 1'b1; in_mem_read = 1'b1; in_funct3 = 3'b010; in_alu_result = 32'h40;
        in_rd = 5'd3; in_reg_write = 1'b1; dmem_gnt = 1'b1;
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("rstmid_stall", {31'h0, stall}, 32'h0);
        check("rstmid_req", {31'h0, dmem_req}, 32'h0);
        check("rstmid_valid", {31'h0, out_valid}, 32'h0);
        check("rstmid_fault", {31'h0, fault}, 32'h0);
        idle_inputs();
        @(posedge clk); #1;
        reset = 1'b0;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_1111;
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        check("late_rvalid_valid", {31'h0, out_valid}, 32'h0);
        check("late_rvalid_rw", {31'h0, out_reg_write}, 32'h0);
        run_access("post_rst_lw", 1'b0, 3'b010, 32'h040, 32'h0, 32'hCAFE_F00D, 0, 1, 1, 1, 4'b1111, 32'h0, 32'hCAFE_F00D, 1'b0);

        // Back-to-back ADD, LHU, ADD: exactly three bundles in order.
        @(posedge clk); #1;
        mon_en = 1'b1;
        in_valid = 1'b1; in_alu_result = 32'h55; in_rd = 5'd1; in_reg_write = 1'b1;
        @(posedge clk); #1;
        in_mem_read = 1'b1; in_funct3 = 3'b101; in_alu_result = 32'h0; in_rd = 5'd2; dmem_gnt = 1'b1;
        @(negedge clk);
        check("b2b_stall_gnt", {31'h0, stall}, 32'h1);
        @(posedge clk); #1;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h0000_F00D;
        @(negedge clk);
        check("b2b_stall_rvalid", {31'h0, stall}, 32'h0);
        @(posedge clk); #1;
        dmem_rvalid = 1'b0; in_mem_read = 1'b0; in_funct3 = 3'b000; in_alu_result = 32'h77; in_rd = 5'd3;
        @(posedge clk); #1;
        idle_inputs();
        @(posedge clk); #1;
        @(posedge clk); #1;
        mon_en = 1'b0;
        check("b2b_count", mon_q.size(), 32'd3);
        if (mon_q.size() == 3) begin
            check("b2b_0", mon_q[0], 32'h55);
            check("b2b_1", mon_q[1], 32'h0000_F00D);
            check("b2b_2", mon_q[2], 32'h77);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
